// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// It processes one input bit per clock and uses a Start/Busy/Done handshake.
// The result registers keep their value until the next conversion completes.
// Optional feature macro: BCD_BLANK_LEAD_EN adds the Blank output, which flags leading zeros.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                CLOCK_50,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [WIDTH-1:0]    Bin,
    output logic                Busy,
    output logic                Done,
    output logic [4*DIGITS-1:0] Bcd,
    output logic                Overflow
`ifdef BCD_BLANK_LEAD_EN
    ,
    output logic [DIGITS-1:0]   Blank
`endif
);

    localparam int unsigned BW    = 4 * DIGITS;
    localparam int unsigned TW    = BW + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]       r_state;
    // Scratch BCD digits sit above the binary operand in a single shift register.
    logic [TW-1:0]    r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_acc;
    logic             r_done;
    logic [BW-1:0]    r_bcd;
    logic             r_ovf;

    logic [TW-1:0]    w_adj;
    logic [TW-1:0]    w_next;
    logic             w_carry;
    logic [BW-1:0]    w_result;
    logic             w_last;

    // Add 3 to every scratch digit that is 5 or more, before the shift.
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_shift[WIDTH + 4*i +: 4] >= 4'd5) begin
                w_adj[WIDTH + 4*i +: 4] = r_shift[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    // A bit that leaves the top digit means the value needs more digits than DIGITS.
    assign w_carry  = w_adj[TW-1];
    assign w_next   = {w_adj[TW-2:0], 1'b0};
    assign w_result = w_next[TW-1 -: BW];
    assign w_last   = (r_cnt == CNT_W'(1));

    // Conversion FSM, scratch shifter and the result registers.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        r_shift   <= {{BW{1'b0}}, Bin};
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    r_shift   <= w_next;
                    r_ovf_acc <= r_ovf_acc | w_carry;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_bcd   <= w_result;
                        r_ovf   <= r_ovf_acc | w_carry;
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign Busy     = (r_state == StShift);
    assign Done     = r_done;
    assign Bcd      = r_bcd;
    assign Overflow = r_ovf;

`ifdef BCD_BLANK_LEAD_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;
    logic              w_zero_run;

    // A digit is blanked when it and every higher digit are zero. The ones digit is never blanked.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (w_result[4*i +: 4] == 4'd0);
            w_blank[i] = w_zero_run;
        end
    end

    // Blank flags are updated together with Bcd on the final shift.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_blank <= '0;
        end else if (r_state == StShift && w_last) begin
            r_blank <= w_blank;
        end
    end

    assign Blank = r_blank;
`endif

endmodule
